// File: rtl/dionysus_sdram_clk_sup_pkg.sv
// rtl/dionysus_sdram_clk_sup_pkg.sv - state encoding shared by the PLL lock supervisor,
// the status-register block and the bench.
package dionysus_sdram_clk_sup_pkg;

  typedef enum logic [2:0] {
    ST_RESET_PLL   = 3'd0,
    ST_WAIT_LOCK   = 3'd1,
    ST_STABLE_WAIT = 3'd2,
    ST_RUN         = 3'd3,
    ST_FAIL        = 3'd4
  } sup_state_t;

  localparam int CNT_W        = 16;
  localparam int RETRY_W      = 4;
  localparam int LOSS_W       = 8;
  localparam logic [LOSS_W-1:0] LOSS_SAT = 8'd255;

endpackage

// File: rtl/dionysus_sync2.sv
// rtl/dionysus_sync2.sv - generic two-flop synchronizer, async active-low reset.
module dionysus_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/dionysus_sdram_clk_supervisor.sv
// rtl/dionysus_sdram_clk_supervisor.sv - SDRAM PLL lock supervisor: PLL reset sequencing,
// lock filtering, timeout/retry and lock-loss statistics.
module dionysus_sdram_clk_supervisor
  import dionysus_sdram_clk_sup_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 4096,
  parameter int STABLE_CYCLES  = 256,
  parameter int LOSS_FILTER    = 4,
  parameter int MAX_RETRIES    = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_pll_locked,
  input  logic         i_retry,
  output logic         o_pll_rst,
  output logic         o_ready,
  output logic         o_fail,
  output logic [2:0]   o_state,
  output logic [3:0]   o_retry_count,
  output logic [7:0]   o_loss_count
);

  localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST     = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   LOSS_LAST   = CNT_W'(LOSS_FILTER - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

  sup_state_t         state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic [RETRY_W-1:0] retry_cnt, retry_nx, retry_inc;
  logic [LOSS_W-1:0]  loss_cnt, loss_nx;
  logic               lock_s, attempt_fail, pll_rst;

  dionysus_sync2 u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (i_pll_locked),
    .q     (lock_s)
  );

  assign retry_inc = retry_cnt + 1'b1;

  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt + 1'b1;
    retry_nx     = retry_cnt;
    loss_nx      = loss_cnt;
    attempt_fail = 1'b0;

    case (state)
      ST_RESET_PLL: begin
        if (cnt == RST_LAST) state_nx = ST_WAIT_LOCK;
      end
      ST_WAIT_LOCK: begin
        // lock is checked first so it wins on the timeout cycle
        if (lock_s) state_nx = (STABLE_LAST == '0) ? ST_RUN : ST_STABLE_WAIT;
        else if (cnt == TO_LAST) attempt_fail = 1'b1;
      end
      ST_STABLE_WAIT: begin
        if (!lock_s) attempt_fail = 1'b1;
        else if (cnt == STABLE_LAST) state_nx = ST_RUN;
      end
      ST_RUN: begin
        if (lock_s) begin
          cnt_nx = '0;
        end else if (cnt == LOSS_LAST) begin
          state_nx = ST_RESET_PLL;
          if (loss_cnt != LOSS_SAT) loss_nx = loss_cnt + 1'b1;
        end
      end
      ST_FAIL: begin
        if (i_retry) begin
          retry_nx = '0;
          state_nx = ST_RESET_PLL;
        end
      end
      default: state_nx = ST_RESET_PLL;
    endcase

    if (attempt_fail) begin
      retry_nx = retry_inc;
      state_nx = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_RESET_PLL;
    end

    // The lock sample that moves WAIT_LOCK to STABLE_WAIT is the first stable sample.
    if (state_nx != state) cnt_nx = (state_nx == ST_STABLE_WAIT) ? CNT_W'(1) : '0;
    if (state_nx == ST_RUN) retry_nx = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_RESET_PLL;
      cnt       <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      pll_rst   <= 1'b1;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      retry_cnt <= retry_nx;
      loss_cnt  <= loss_nx;
      pll_rst   <= (state_nx == ST_RESET_PLL) || (state_nx == ST_FAIL);
    end
  end

  assign o_pll_rst     = pll_rst;
  assign o_ready       = (state == ST_RUN);
  assign o_fail        = (state == ST_FAIL);
  assign o_state       = state;
  assign o_retry_count = retry_cnt;
  assign o_loss_count  = loss_cnt;

endmodule

// File: tb/tb_dionysus_sdram_clk_supervisor.sv
// tb/tb_dionysus_sdram_clk_supervisor.sv - directed self-checking bench for the PLL lock supervisor.
module tb_dionysus_sdram_clk_supervisor;
  import dionysus_sdram_clk_sup_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_locked;
  logic       retry;
  logic       pll_rst;
  logic       ready;
  logic       fail;
  logic [2:0] state;
  logic [3:0] retry_count;
  logic [7:0] loss_count;

  int checks = 0;
  int errors = 0;

  dionysus_sdram_clk_supervisor #(
    .PLL_RST_CYCLES (4),
    .LOCK_TIMEOUT   (32),
    .STABLE_CYCLES  (8),
    .LOSS_FILTER    (3),
    .MAX_RETRIES    (2)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_pll_locked  (pll_locked),
    .i_retry       (retry),
    .o_pll_rst     (pll_rst),
    .o_ready       (ready),
    .o_fail        (fail),
    .o_state       (state),
    .o_retry_count (retry_count),
    .o_loss_count  (loss_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_pll_rst"}, 32'(pll_rst), 1);
    check({tag, "_ready"},   32'(ready),   0);
    check({tag, "_fail"},    32'(fail),    0);
    check({tag, "_state"},   32'(state),   32'(ST_RESET_PLL));
    check({tag, "_retry"},   32'(retry_count), 0);
    check({tag, "_loss"},    32'(loss_count),  0);
  endtask

  initial begin
    int n;
    logic glitch_drop;
    logic loop_timeout;

    rst_n      = 1'b0;
    pll_locked = 1'b0;
    retry      = 1'b0;
    #23;
    check_reset_values("por");

    // clean bring-up
    tick();
    rst_n = 1'b1;
    n = 0;
    while (pll_rst && n < 100) begin tick(); n++; end
    check("bringup_rst_width", n, 4);
    check("bringup_wait_state", 32'(state), 32'(ST_WAIT_LOCK));
    repeat (10) tick();
    pll_locked = 1'b1;
    n = 0;
    while (!ready && n < 100) begin tick(); n++; end
    check("bringup_ready_latency", n, 10);
    check("bringup_state", 32'(state), 32'(ST_RUN));
    check("bringup_retry", 32'(retry_count), 0);
    check("bringup_pll_rst", 32'(pll_rst), 0);

    // retry pulse outside FAIL is ignored
    retry = 1'b1;
    tick();
    retry = 1'b0;
    check("retry_in_run_state", 32'(state), 32'(ST_RUN));

    // two-cycle glitch is filtered
    pll_locked = 1'b0;
    tick();
    tick();
    pll_locked = 1'b1;
    glitch_drop = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (!ready) glitch_drop = 1'b1;
    end
    check("glitch_ready_held", 32'(glitch_drop), 0);
    check("glitch_loss", 32'(loss_count), 0);

    // three-cycle drop is a loss; keep lock low afterwards for the timeout test
    pll_locked = 1'b0;
    n = 0;
    while (ready && n < 100) begin tick(); n++; end
    check("loss_latency", n, 5);
    check("loss_count_1", 32'(loss_count), 1);
    check("loss_pll_rst", 32'(pll_rst), 1);
    check("loss_state", 32'(state), 32'(ST_RESET_PLL));

    // timeout path into FAIL
    n = 0;
    while (pll_rst && n < 100) begin tick(); n++; end
    check("to_first_rst_width", n, 4);
    n = 0;
    while (!pll_rst && n < 100) begin tick(); n++; end
    check("to_first_wait_len", n, 32);
    check("to_retry_1", 32'(retry_count), 1);
    n = 0;
    while (pll_rst && !fail && n < 100) begin tick(); n++; end
    check("to_second_rst_width", n, 4);
    n = 0;
    while (!fail && n < 100) begin tick(); n++; end
    check("to_fail", 32'(fail), 1);
    check("to_fail_state", 32'(state), 32'(ST_FAIL));
    check("to_fail_retry", 32'(retry_count), 2);
    check("to_fail_pll_rst", 32'(pll_rst), 1);
    check("to_fail_ready", 32'(ready), 0);

    retry = 1'b1;
    tick();
    retry = 1'b0;
    check("retry_state", 32'(state), 32'(ST_RESET_PLL));
    check("retry_count_clr", 32'(retry_count), 0);
    check("retry_fail_clr", 32'(fail), 0);

    // unstable lock inside STABLE_WAIT
    pll_locked = 1'b1;
    n = 0;
    while (state != 3'(ST_STABLE_WAIT) && n < 100) begin tick(); n++; end
    check("unstable_reach_sw", 32'(state), 32'(ST_STABLE_WAIT));
    tick();
    pll_locked = 1'b0;
    tick();
    tick();
    check("unstable_still_sw", 32'(state), 32'(ST_STABLE_WAIT));
    tick();
    check("unstable_state", 32'(state), 32'(ST_RESET_PLL));
    check("unstable_retry", 32'(retry_count), 1);
    pll_locked = 1'b1;
    n = 0;
    while (!ready && n < 200) begin tick(); n++; end
    check("relock_ready", 32'(ready), 1);
    check("relock_retry", 32'(retry_count), 0);

    // drive the loss counter into saturation: 256 losses in total
    loop_timeout = 1'b0;
    for (int i = 0; i < 255; i++) begin
      pll_locked = 1'b0;
      n = 0;
      while (ready && n < 20) begin tick(); n++; end
      if (ready) loop_timeout = 1'b1;
      pll_locked = 1'b1;
      n = 0;
      while (!ready && n < 100) begin tick(); n++; end
      if (!ready) loop_timeout = 1'b1;
      if (i == 253) check("loss_count_255", 32'(loss_count), 255);
    end
    check("sat_loop_timeout", 32'(loop_timeout), 0);
    check("sat_loss_count", 32'(loss_count), 255);
    check("sat_ready", 32'(ready), 1);

    // asynchronous reset mid-RUN
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values("async_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
